// File: rtl/uart_pos_cmd_parser_if.sv
// Byte-stream and position/status signals between the UART receiver side and the parser.
// The master drives bytes in; the slave (the parser) drives position and status out.
interface uart_pos_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] position_x;
  logic [7:0] position_y;
  logic       pos_valid;
  logic       cmd_err;
  logic [7:0] err_count;
  logic       busy;

  modport master (
    output rx_data, rx_valid,
    input  position_x, position_y, pos_valid, cmd_err, err_count, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output position_x, position_y, pos_valid, cmd_err, err_count, busy
  );
endinterface

// File: rtl/uart_pos_cmd_parser.sv
// Parses ASCII "X<hex>[<hex>]<CR|LF>", "Y..." and "H<CR|LF>" commands into grid coordinates,
// with per-byte inactivity timeout and a saturating count of rejected frames.
module uart_pos_cmd_parser_chk #(
  parameter int unsigned X_MAX = 15,
  parameter int unsigned Y_MAX = 15
) (
  input logic       clk,
  input logic       reset_p,
  input logic [7:0] position_x,
  input logic [7:0] position_y,
  input logic       pos_valid,
  input logic       cmd_err
);
  a_pulse_excl: assert property (@(posedge clk) disable iff (reset_p) !(pos_valid && cmd_err));
  a_x_range:    assert property (@(posedge clk) disable iff (reset_p) position_x <= 8'(X_MAX));
  a_y_range:    assert property (@(posedge clk) disable iff (reset_p) position_y <= 8'(Y_MAX));
endmodule

module uart_pos_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
  parameter int unsigned X_MAX          = 15,
  parameter int unsigned Y_MAX          = 15
) (
  input logic                 clk,
  input logic                 reset_p,
  uart_pos_cmd_parser_if.slave bus
);
  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    X_LIM   = 8'(X_MAX);
  localparam logic [7:0]    Y_LIM   = 8'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_D0   = 3'd1,
    S_D1   = 3'd2,
    S_TERM = 3'd3,
    S_HOME = 3'd4
  } state_t;

  state_t      state;
  logic          axis_y;
  logic [7:0]    acc;
  logic [CW-1:0] cnt;
  logic [7:0]    position_x;
  logic [7:0]    position_y;
  logic          pos_valid;
  logic          cmd_err;
  logic [7:0]    err_count;

  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // 'A'..'F' and 'a'..'f' both carry 1..6 in the low nibble.
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    if (b <= 8'h39) begin
      return b[3:0];
    end else begin
      return b[3:0] + 4'd9;
    end
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function automatic logic is_axis(input logic [7:0] b);
    return (b == 8'h58) || (b == 8'h78) || (b == 8'h59) || (b == 8'h79);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Parser state machine with registered position and status outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state      <= S_IDLE;
      axis_y     <= 1'b0;
      acc        <= 8'd0;
      cnt        <= '0;
      position_x <= 8'd0;
      position_y <= 8'd0;
      pos_valid  <= 1'b0;
      cmd_err    <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      pos_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (bus.rx_valid || (state == S_IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (bus.rx_valid) begin
        case (state)
          S_IDLE: begin
            if (is_axis(bus.rx_data)) begin
              axis_y <= bus.rx_data[0];
              state  <= S_D0;
            end else if ((bus.rx_data == 8'h48) || (bus.rx_data == 8'h68)) begin
              state <= S_HOME;
            end else if (is_term(bus.rx_data) || (bus.rx_data == 8'h20)) begin
              state <= S_IDLE;
            end else begin
              cmd_err   <= 1'b1;
              err_count <= sat_inc(err_count);
            end
          end
          S_D0: begin
            if (is_hex(bus.rx_data)) begin
              acc   <= {4'h0, hex_val(bus.rx_data)};
              state <= S_D1;
            end else begin
              cmd_err   <= 1'b1;
              err_count <= sat_inc(err_count);
              state     <= S_IDLE;
            end
          end
          S_D1: begin
            if (is_hex(bus.rx_data)) begin
              // acc holds a single digit here, so the shift is the 8-bit acc*16+digit.
              acc   <= {acc[3:0], hex_val(bus.rx_data)};
              state <= S_TERM;
            end else if (is_term(bus.rx_data)) begin
              if (axis_y && (acc <= Y_LIM)) begin
                position_y <= acc;
                pos_valid  <= 1'b1;
              end else if (!axis_y && (acc <= X_LIM)) begin
                position_x <= acc;
                pos_valid  <= 1'b1;
              end else begin
                cmd_err   <= 1'b1;
                err_count <= sat_inc(err_count);
              end
              state <= S_IDLE;
            end else begin
              cmd_err   <= 1'b1;
              err_count <= sat_inc(err_count);
              state     <= S_IDLE;
            end
          end
          S_TERM: begin
            if (is_term(bus.rx_data)) begin
              if (axis_y && (acc <= Y_LIM)) begin
                position_y <= acc;
                pos_valid  <= 1'b1;
              end else if (!axis_y && (acc <= X_LIM)) begin
                position_x <= acc;
                pos_valid  <= 1'b1;
              end else begin
                cmd_err   <= 1'b1;
                err_count <= sat_inc(err_count);
              end
            end else begin
              cmd_err   <= 1'b1;
              err_count <= sat_inc(err_count);
            end
            state <= S_IDLE;
          end
          S_HOME: begin
            if (is_term(bus.rx_data)) begin
              position_x <= 8'd0;
              position_y <= 8'd0;
              pos_valid  <= 1'b1;
            end else begin
              cmd_err   <= 1'b1;
              err_count <= sat_inc(err_count);
            end
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end else if ((state != S_IDLE) && (cnt == TO_LAST)) begin
        // A byte arriving in the timeout cycle takes the branch above instead.
        cmd_err   <= 1'b1;
        err_count <= sat_inc(err_count);
        state     <= S_IDLE;
        cnt       <= '0;
      end else begin
        state <= state;
      end
    end
  end

  assign bus.position_x = position_x;
  assign bus.position_y = position_y;
  assign bus.pos_valid  = pos_valid;
  assign bus.cmd_err    = cmd_err;
  assign bus.err_count  = err_count;
  assign bus.busy       = (state != S_IDLE);

  uart_pos_cmd_parser_chk #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_chk (
    .clk        (clk),
    .reset_p    (reset_p),
    .position_x (position_x),
    .position_y (position_y),
    .pos_valid  (pos_valid),
    .cmd_err    (cmd_err)
  );
endmodule

// File: tb/tb_uart_pos_cmd_parser.sv
// Scoreboard bench for uart_pos_cmd_parser: each byte sent may queue an expected pulse,
// and a negedge monitor matches pos_valid/cmd_err pulses against the queue, cycle-exact.
module tb_uart_pos_cmd_parser;
  logic clk = 1'b0;
  logic reset_p;
  always #5 clk = ~clk;

  uart_pos_cmd_parser_if bus();

  uart_pos_cmd_parser #(.TIMEOUT_CYCLES(100), .X_MAX(15), .Y_MAX(15)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  typedef struct {
    int         kind;   // 1 = pos_valid, 2 = cmd_err
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] ec;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [7:0] exp_x  = 8'd0;
  logic [7:0] exp_y  = 8'd0;
  logic [7:0] exp_ec = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one byte for exactly one cycle; kind != 0 queues the expected pulse lag cycles on.
  task automatic send_byte(input logic [7:0] b, input int kind, input int lag);
    exp_t e;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    if (kind == 2) exp_ec = (exp_ec == 8'hFF) ? 8'hFF : exp_ec + 8'd1;
    if (kind != 0) begin
      e.kind = kind; e.x = exp_x; e.y = exp_y; e.ec = exp_ec; e.due = cyc + lag;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"},  bus.position_x, 8'd0);
    check({tag, "_y"},  bus.position_y, 8'd0);
    check({tag, "_pv"}, bus.pos_valid, 1'b0);
    check({tag, "_ce"}, bus.cmd_err, 1'b0);
    check({tag, "_ec"}, bus.err_count, 8'd0);
    check({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard at its due cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      check("missed_pulse", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if (!reset_p && (bus.pos_valid || bus.cmd_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {bus.cmd_err, bus.pos_valid}, 2'b00);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {bus.cmd_err, bus.pos_valid}, e.kind);
        check("pulse_cycle", cyc, e.due);
        check("pos_x", bus.position_x, e.x);
        check("pos_y", bus.position_y, e.y);
        check("err_count", bus.err_count, e.ec);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset_p      = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle(3);
    reset_p = 1'b0;
    idle(1);
    check_reset_vals("rst");

    // "X5\r" with 10-cycle gaps
    send_byte("X", 0, 1); idle(9);
    send_byte("5", 0, 1); idle(9);
    exp_x = 8'd5;
    send_byte(8'h0D, 1, 1);
    check("x5_pulse_width", bus.pos_valid, 1'b1);
    idle(1);
    check("x5_pulse_end", bus.pos_valid, 1'b0);
    idle(2);
    check("x5_x", bus.position_x, 8'd5);
    check("x5_y", bus.position_y, 8'd0);
    check("x5_ec", bus.err_count, 8'd0);

    // "y0a\n" then "Xf\r", back to back
    send_byte("y", 0, 1); send_byte("0", 0, 1); send_byte("a", 0, 1);
    exp_y = 8'd10;
    send_byte(8'h0A, 1, 1);
    send_byte("X", 0, 1); send_byte("f", 0, 1);
    exp_x = 8'd15;
    send_byte(8'h0D, 1, 1);
    idle(3);
    check("y10", bus.position_y, 8'd10);
    check("x15", bus.position_x, 8'd15);

    // out-of-range value, then bad digit
    send_byte("X", 0, 1); send_byte("1", 0, 1); send_byte("F", 0, 1);
    send_byte(8'h0D, 2, 1);
    idle(2);
    check("x31_keep", bus.position_x, 8'd15);
    check("x31_ec", bus.err_count, 8'd1);
    send_byte("X", 0, 1);
    check("xz_busy_mid", bus.busy, 1'b1);
    send_byte("Z", 2, 1);
    idle(2);
    check("xz_ec", bus.err_count, 8'd2);
    check("xz_busy", bus.busy, 1'b0);

    // timeout 100 cycles after the 'Y' strobe
    send_byte("Y", 2, 101);
    idle(99);
    check("to_busy_before", bus.busy, 1'b1);
    idle(1);
    check("to_busy_after", bus.busy, 1'b0);
    check("to_err_pulse", bus.cmd_err, 1'b1);
    idle(2);
    send_byte("Y", 0, 1); send_byte("3", 0, 1);
    exp_y = 8'd3;
    send_byte(8'h0A, 1, 1);
    idle(2);
    check("y3", bus.position_y, 8'd3);
    check("to_ec", bus.err_count, 8'd3);

    // home command
    send_byte("X", 0, 1); send_byte("7", 0, 1); exp_x = 8'd7; send_byte(8'h0D, 1, 1);
    send_byte("Y", 0, 1); send_byte("9", 0, 1); exp_y = 8'd9; send_byte(8'h0A, 1, 1);
    idle(1);
    check("pre_home_x", bus.position_x, 8'd7);
    check("pre_home_y", bus.position_y, 8'd9);
    send_byte("H", 0, 1);
    exp_x = 8'd0; exp_y = 8'd0;
    send_byte(8'h0D, 1, 1);
    idle(2);
    check("home_x", bus.position_x, 8'd0);
    check("home_y", bus.position_y, 8'd0);

    // whitespace in idle: no pulses
    send_byte(8'h0D, 0, 1); send_byte(8'h0A, 0, 1);
    send_byte(8'h20, 0, 1); send_byte(8'h0A, 0, 1);
    idle(3);
    check("ws_busy", bus.busy, 1'b0);

    // reset mid-frame discards the partial frame
    send_byte("Y", 0, 1); send_byte("2", 0, 1); exp_y = 8'd2; send_byte(8'h0A, 1, 1);
    idle(2);
    send_byte("X", 0, 1); send_byte("3", 0, 1);
    reset_p = 1'b1;
    idle(1);
    reset_p = 1'b0;
    exp_x = 8'd0; exp_y = 8'd0; exp_ec = 8'd0;
    send_byte(8'h0D, 0, 1);
    idle(2);
    check_reset_vals("midrst");

    // 300 malformed bytes, back to back
    for (int i = 0; i < 300; i++) send_byte("#", 2, 1);
    idle(3);
    check("sat_ec", bus.err_count, 8'd255);
    check("sat_busy", bus.busy, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
